// File: rtl/crc_serial_framer_pkg.sv
`default_nettype none
// ============================================================================
// crc_serial_framer_pkg : shared state encoding and mode constants
// Revision 1.0
// ============================================================================
package crc_serial_framer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    // x^3 + x + 1 with the implicit x^3 term dropped
    localparam logic [2:0] DEFAULT_POLY = 3'b011;

endpackage
`default_nettype wire

// File: rtl/crc_serial_framer_lfsr_step.sv
`default_nettype none
// ============================================================================
// crc_lfsr_step : one serial CRC shift, combinational; holds r when en is low
// Revision 1.0
// ============================================================================
module crc_lfsr_step #(
    parameter int               CRC_W = 3,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(3'b011)
) (
    input  logic [CRC_W-1:0] r,
    input  logic             data_bit,
    input  logic             en,
    output logic [CRC_W-1:0] r_next
);

    logic fb;

    always_comb begin
        fb     = data_bit ^ r[CRC_W-1];
        r_next = r;
        if (en) begin
            r_next = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

endmodule
`default_nettype wire

// File: rtl/crc_serial_framer.sv
`default_nettype none
// ============================================================================
// crc_serial_framer : serial CRC generator (data + appended CRC) or checker
// Revision 1.0
// ============================================================================
module crc_serial_framer
    import crc_serial_framer_pkg::*;
#(
    parameter int               CRC_W    = 3,
    parameter logic [CRC_W-1:0] POLY     = CRC_W'(DEFAULT_POLY),
    parameter int               DATA_LEN = 8,
    parameter logic [CRC_W-1:0] INIT     = '0
) (
    input  logic             GCLK,
    input  logic             CLEAR_bar,
    input  logic             Start,
    input  logic             Mode,
    input  logic             Serial_In,
    input  logic             In_Valid,
    output logic             Serial_Out,
    output logic             Out_Valid,
    output logic             Busy,
    output logic             Done,
    output logic             ERROR,
    output logic [CRC_W-1:0] Remainder
);

    localparam int CNT_MAX = (DATA_LEN > CRC_W) ? DATA_LEN : CRC_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_LEN - 1);
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W - 1);

    state_t             state, state_next;
    logic [CRC_W-1:0]   r, r_next, lfsr_r;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               mode, mode_next;
    logic               error, error_next;
    logic               step_en;

    crc_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .r        (r),
        .data_bit (Serial_In),
        .en       (step_en),
        .r_next   (lfsr_r)
    );

    always_ff @(posedge GCLK or negedge CLEAR_bar) begin
        if (!CLEAR_bar) begin
            state <= IDLE;
            r     <= '0;
            cnt   <= '0;
            mode  <= MODE_GEN;
            error <= 1'b0;
        end else begin
            state <= state_next;
            r     <= r_next;
            cnt   <= cnt_next;
            mode  <= mode_next;
            error <= error_next;
        end
    end

    always_comb begin
        state_next = state;
        r_next     = r;
        cnt_next   = cnt;
        mode_next  = mode;
        error_next = error;
        step_en    = 1'b0;
        Serial_Out = 1'b0;
        Out_Valid  = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;

        case (state)
            IDLE: begin
                // A bit presented alongside Start is deliberately not consumed
                if (Start) begin
                    state_next = DATA;
                    r_next     = INIT;
                    cnt_next   = '0;
                    error_next = 1'b0;
                    mode_next  = Mode;
                end
            end
            DATA: begin
                Busy       = 1'b1;
                Serial_Out = Serial_In;
                Out_Valid  = In_Valid;
                step_en    = In_Valid;
                r_next     = lfsr_r;
                if (In_Valid) begin
                    if (cnt == DATA_LAST) begin
                        state_next = TAIL;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            TAIL: begin
                Busy = 1'b1;
                if (mode == MODE_GEN) begin
                    // Shift the finished CRC out MSB first, ignoring the input
                    Serial_Out = r[CRC_W-1];
                    Out_Valid  = 1'b1;
                    r_next     = {r[CRC_W-2:0], 1'b0};
                    if (cnt == CRC_LAST) begin
                        state_next = DONE;
                        cnt_next   = '0;
                        error_next = 1'b0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end else begin
                    step_en = In_Valid;
                    r_next  = lfsr_r;
                    if (In_Valid) begin
                        if (cnt == CRC_LAST) begin
                            state_next = DONE;
                            cnt_next   = '0;
                            error_next = |lfsr_r;
                        end else begin
                            cnt_next = cnt + 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                Busy       = 1'b1;
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign ERROR     = error;
    assign Remainder = r;

endmodule
`default_nettype wire

// File: tb/tb_crc_serial_framer.sv
`default_nettype none
// ============================================================================
// tb_crc_serial_framer : vector table, corner sequences and random frames
// Revision 1.0
// ============================================================================
module tb_crc_serial_framer;

    logic       GCLK = 1'b0;
    logic       CLEAR_bar;
    logic       start_a, start_b, Mode, Serial_In, In_Valid;
    logic       so_a, ov_a, busy_a, done_a, err_a;
    logic       so_b, ov_b, busy_b, done_b, err_b;
    logic [2:0] rem_a;
    logic [7:0] rem_b;
    logic       cur_sel;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 GCLK = ~GCLK;

    crc_serial_framer #(.CRC_W(3), .POLY(3'b011), .DATA_LEN(4), .INIT(3'b000)) dut_a (
        .GCLK(GCLK), .CLEAR_bar(CLEAR_bar), .Start(start_a), .Mode(Mode),
        .Serial_In(Serial_In), .In_Valid(In_Valid), .Serial_Out(so_a), .Out_Valid(ov_a),
        .Busy(busy_a), .Done(done_a), .ERROR(err_a), .Remainder(rem_a));

    crc_serial_framer #(.CRC_W(8), .POLY(8'h07), .DATA_LEN(8), .INIT(8'h00)) dut_b (
        .GCLK(GCLK), .CLEAR_bar(CLEAR_bar), .Start(start_b), .Mode(Mode),
        .Serial_In(Serial_In), .In_Valid(In_Valid), .Serial_Out(so_b), .Out_Valid(ov_b),
        .Busy(busy_b), .Done(done_b), .ERROR(err_b), .Remainder(rem_b));

    wire       so_sel   = cur_sel ? so_b   : so_a;
    wire       ov_sel   = cur_sel ? ov_b   : ov_a;
    wire       busy_sel = cur_sel ? busy_b : busy_a;
    wire       done_sel = cur_sel ? done_b : done_a;
    wire       err_sel  = cur_sel ? err_b  : err_a;
    wire [7:0] rem_sel  = cur_sel ? rem_b  : {5'b0, rem_a};

    typedef struct {
        logic        sel;
        logic        mode;
        logic [15:0] frame;
        int          gap;      // 0 none, 1 alternate cycles, 2 random
        logic [15:0] exp_out;
        logic [7:0]  exp_rem;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: long division of msg(x)*x^w by the full generator g(x)
    function automatic logic [7:0] poly_rem(input logic [31:0] msg, input int n,
                                            input int w, input logic [16:0] g);
        logic [47:0] a;
        logic [47:0] gg;
        a  = {16'b0, msg} << w;
        gg = 48'(g);
        for (int i = n + w - 1; i >= w; i--)
            if (a[i]) a = a ^ (gg << (i - w));
        return 8'(a & ((48'd1 << w) - 48'd1));
    endfunction

    task automatic set_start(input logic sel, input logic v);
        start_a = sel ? 1'b0 : v;
        start_b = sel ? v : 1'b0;
    endtask

    task automatic run_frame(input logic sel, input logic mode, input logic [15:0] frame,
                             input int gap, output logic [31:0] outv, output int outn,
                             output logic [7:0] rem, output logic err);
        int  w, dl, total, idx, cyc;
        bit  done_seen;
        logic iv;
        w = sel ? 8 : 3;
        dl = sel ? 8 : 4;
        total = dl + (mode ? w : 0);
        outv = 0; outn = 0; rem = 0; err = 0; done_seen = 0;
        cur_sel = sel;
        @(negedge GCLK);
        set_start(sel, 1'b1);
        Mode = mode;
        In_Valid = 1'($urandom_range(1));
        Serial_In = 1'($urandom_range(1));
        @(posedge GCLK);
        @(negedge GCLK);
        Mode = ~mode;
        idx = 0; cyc = 0;
        while (!done_seen && cyc < 200) begin
            set_start(sel, $urandom_range(3) == 0);
            case (gap)
                0: iv = 1'b1;
                1: iv = (cyc % 2 == 1);
                default: iv = ($urandom_range(2) != 0);
            endcase
            if (idx >= total) iv = 1'($urandom_range(1));
            In_Valid  = iv;
            Serial_In = (idx < total) ? frame[total-1-idx] : 1'($urandom_range(1));
            #1;
            if (ov_sel) begin
                outv = {outv[30:0], so_sel};
                outn++;
            end
            if (done_sel) begin
                done_seen = 1;
                rem = rem_sel;
                err = err_sel;
            end
            @(posedge GCLK);
            if (iv && idx < total) idx++;
            @(negedge GCLK);
            cyc++;
        end
        set_start(sel, 1'b0);
        In_Valid = 1'b0;
        if (!done_seen) check("done_timeout", 0, 1);
    endtask

    task automatic verify(input string tag, input vec_t v);
        logic [31:0] outv;
        int          outn, expn;
        logic [7:0]  rem;
        logic        err;
        expn = (v.sel ? 8 : 4) + ((v.mode == 1'b0) ? (v.sel ? 8 : 3) : 0);
        run_frame(v.sel, v.mode, v.frame, v.gap, outv, outn, rem, err);
        check({tag, "_out_count"}, 32'(outn), 32'(expn));
        check({tag, "_out_bits"}, outv, {16'b0, v.exp_out});
        check({tag, "_rem_done"}, {24'b0, rem}, {24'b0, v.exp_rem});
        check({tag, "_err_done"}, {31'b0, err}, {31'b0, v.exp_err});
        #1;
        check({tag, "_idle_hold"}, {busy_sel, done_sel, ov_sel, err_sel, rem_sel},
              {3'b000, v.exp_err, v.exp_rem});
    endtask

    vec_t vecs[7];

    initial begin
        logic [15:0] data, crc, frame;
        logic [31:0] outv;
        int          outn, dones;
        logic [7:0]  rem;
        logic        err;
        vec_t        rv;

        vecs[0] = '{1'b0, 1'b0, 16'h000D, 0, 16'h0069, 8'h00, 1'b0};  // 1101 -> 1101_001
        vecs[1] = '{1'b0, 1'b1, 16'h0069, 0, 16'h000D, 8'h00, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 16'h000D, 1, 16'h0069, 8'h00, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 16'h0031, 0, 16'h3197, 8'h00, 1'b0};  // CRC-8/0x07 of 8'h31 is 8'h97
        vecs[4] = '{1'b1, 1'b1, 16'h3197, 2, 16'h0031, 8'h00, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 16'h3196, 0, 16'h0031, 8'h07, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 16'h006B, 2, 16'h000D, 8'h06, 1'b1};  // single-bit error

        CLEAR_bar = 1'b0;
        start_a = 0; start_b = 0; Mode = 0; Serial_In = 0; In_Valid = 0; cur_sel = 0;
        repeat (2) @(negedge GCLK);
        #1;
        check("reset_a", {27'b0, so_a, ov_a, busy_a, done_a, err_a, rem_a}, 0);
        check("reset_b", {19'b0, so_b, ov_b, busy_b, done_b, err_b, rem_b}, 0);
        CLEAR_bar = 1'b1;

        for (int i = 0; i < 7; i++) verify($sformatf("vec%0d", i), vecs[i]);

        // ERROR from vecs[6] stays latched through idle, cleared by next Start
        cur_sel = 0;
        repeat (3) @(negedge GCLK);
        #1;
        check("err_held_idle", {31'b0, err_a}, 1);
        @(negedge GCLK);
        start_a = 1; Mode = 0;
        @(negedge GCLK);
        start_a = 0;
        #1;
        check("err_cleared_start", {30'b0, busy_a, err_a}, 32'b10);
        // Two data bits, then an asynchronous mid-frame reset
        In_Valid = 1; Serial_In = 1;
        repeat (2) @(negedge GCLK);
        Serial_In = 1;
        CLEAR_bar = 1'b0;
        #1;
        check("midframe_reset", {27'b0, so_a, ov_a, busy_a, done_a, err_a, rem_a}, 0);
        In_Valid = 0;
        @(negedge GCLK);
        CLEAR_bar = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge GCLK);
            #1;
            if (done_a || busy_a) dones++;
        end
        check("no_done_after_abort", 32'(dones), 0);
        verify("recover", vecs[0]);

        for (int t = 0; t < 40; t++) begin
            int w, dl;
            logic [16:0] g;
            rv.sel  = 1'($urandom_range(1));
            rv.mode = 1'($urandom_range(1));
            rv.gap  = 2;
            w  = rv.sel ? 8 : 3;
            dl = rv.sel ? 8 : 4;
            g  = rv.sel ? 17'h107 : 17'h00B;
            data = 16'($urandom) & 16'((1 << dl) - 1);
            crc  = {8'b0, poly_rem({16'b0, data}, dl, w, g)};
            if (rv.mode == 1'b0) begin
                rv.frame   = data;
                rv.exp_out = (data << w) | crc;
                rv.exp_rem = 8'h00;
                rv.exp_err = 1'b0;
            end else begin
                frame = (data << w) | crc;
                if ($urandom_range(1) == 1) frame = frame ^ (16'd1 << $urandom_range(dl + w - 1));
                rv.frame   = frame;
                rv.exp_out = frame >> w;
                rv.exp_rem = poly_rem({16'b0, frame}, dl + w, w, g);
                rv.exp_err = (rv.exp_rem != 0);
            end
            verify($sformatf("rand%0d", t), rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
